ddr3_rw_arbiter: RTL and testbench
==================================

# ddr3_rw_arbiter

Sequences the single MIG user port between the burst-write engine and the burst-read engine, treating a configurable DDR3 address window as a ring buffer. The block watches the write-FIFO fill and the read-FIFO fill, and tracks DDR occupancy. It grants one burst at a time, round-robin when both sides are eligible. For each grant it issues a one-cycle start with a fixed length and a wrapping address, then waits for the engine's done pulse. It sits between the user FIFOs and the write and read engines, above the MIG.

## Interface
- ADDR_WIDTH, 28: MIG address width.
- FIFO_CNT_WIDTH, 10: width of FIFO count inputs.
- RD_FIFO_DEPTH, 512: read FIFO depth in DATA_WIDTH words.
- BURST_LEN, 64: beats per burst; must be ≥ 1.
- ADDR_STEP, 16: address increment per beat.
- ADDR_BEGIN, 0: first address of the ring window.
- ADDR_END, 'h4000: exclusive end of the window. (ADDR_END−ADDR_BEGIN) must be a multiple of BURST_LEN·ADDR_STEP.

Ports:
- clk  in  1  single clock, MIG ui_clk.
- rst_n  in  1  asynchronous active-low reset.
- init_calib_complete  in  1  MIG calibration done; no grant while low.
- flush  in  1  pulse; clear pointers and occupancy.
- wr_fifo_cnt  in  FIFO_CNT_WIDTH  words readable from write FIFO.
- rd_fifo_cnt  in  FIFO_CNT_WIDTH  words stored in read FIFO.
- wr_burst_start  out  1  one-cycle write request.
- wr_burst_len  out  ADDR_WIDTH  constant BURST_LEN.
- wr_burst_addr  out  ADDR_WIDTH  write pointer.
- wr_burst_done  in  1  write burst complete pulse.
- rd_burst_start  out  1  one-cycle read request.
- rd_burst_len  out  ADDR_WIDTH  constant BURST_LEN.
- rd_burst_addr  out  ADDR_WIDTH  read pointer.
- rd_burst_done  in  1  read burst complete pulse.
- ddr_fill  out  ADDR_WIDTH  beats held in the ring.
- arb_busy  out  1  high from grant until done.

## Operation
- Eligibility:
  - wr_ok = wr_fifo_cnt ≥ BURST_LEN && ddr_fill ≤ RING_BEATS−BURST_LEN.
  - rd_ok = RD_FIFO_DEPTH−rd_fifo_cnt ≥ BURST_LEN && ddr_fill ≥ BURST_LEN.
  - RING_BEATS = (ADDR_END−ADDR_BEGIN)/ADDR_STEP.
- FSM states: IDLE, ARB, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
  - IDLE→ARB when init_calib_complete=1.
  - ARB→WR_REQ when wr_ok && (!rd_ok || last_grant==RD).
  - ARB→RD_REQ when rd_ok && (!wr_ok || last_grant==WR).
  - ARB stays in ARB otherwise.
  - x_REQ→x_WAIT unconditionally; x_REQ updates last_grant.
  - x_WAIT→ARB on x_burst_done.
- Pointers and occupancy, updated on the done pulse:
  - wr_ptr += BURST_LEN·ADDR_STEP on wr_burst_done; rd_ptr likewise on rd_burst_done.
  - A pointer whose sum equals ADDR_END loads ADDR_BEGIN.
  - ddr_fill += BURST_LEN on write done; −= BURST_LEN on read done. Bursts are serialised, so no simultaneous update.
- Spurious done (wrong channel, or outside WAIT): ignored.
- flush:
  - Applied in IDLE or ARB: wr_ptr = rd_ptr = ADDR_BEGIN, ddr_fill = 0.
  - Applied during REQ/WAIT: latched pending and applied on the cycle the FSM enters ARB; no grant that cycle.
- init_calib_complete falling:
  - In a burst: the burst completes.
  - In ARB: go to IDLE.
- Reset values: all starts 0, arb_busy 0, ddr_fill 0, wr/rd_burst_addr = ADDR_BEGIN, len outputs = BURST_LEN, state IDLE, last_grant = RD (first tie goes to write).

## Timing
- x_burst_start is high exactly the cycle after the ARB decision (REQ state), registered.
- x_burst_addr and x_burst_len are stable from the cycle before start until the cycle after done.
- arb_busy is high in REQ and WAIT.
- Minimum spacing is 2 idle cycles between a done and the next start: the done-cycle transition to ARB, then the ARB decision.
- No timeout: WAIT holds indefinitely until done.
- Reset mid-burst: all outputs return to reset values asynchronously. Engines are reset by the same rst_n.

## Structure
- Shared package ddr3_arb_pkg:
  - FSM state enumeration.
  - GRANT_WR/GRANT_RD encodings.
  - MIG command constants CMD_WRITE=3'b000, CMD_READ=3'b001.
- One sub-module, ddr3_ring_ptr (params ADDR_BEGIN, ADDR_END, STEP; inputs advance, clear; output ptr), instantiated for wr_ptr and rd_ptr.

## Test plan
- Reset, then init_calib_complete=1, wr_fifo_cnt=64, rd_fifo_cnt=0 → wr_burst_start at addr 0x0000 len 64. After wr_burst_done: ddr_fill=64, rd_burst_start at 0x0000 two cycles later.
- Both eligible continuously (wr_fifo_cnt=200, rd FIFO empty, fill≥64) → grants alternate W,R,W,R with addresses advancing by 0x400 each.
- 16 write bursts with no reads → wr_burst_addr wraps 0x3C00→0x0000. ddr_fill=1024 and further writes blocked although wr_fifo_cnt=512.
- rd_fifo_cnt=460 (free 52<64) with fill=128 → no read grant; dropping rd_fifo_cnt to 448 → read granted.
- flush asserted during WR_WAIT → held until wr_burst_done; then pointers=0x0000, ddr_fill=0, no grant that cycle.
- rst_n pulled low during RD_WAIT → starts 0, arb_busy 0, ddr_fill 0, addresses 0x0000 immediately. After release, first tie grants write.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 ring-buffer read/write arbiter.
package ddr3_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT
    } arb_state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/ddr3_ring_ptr.sv
// Burst pointer that walks a DDR address window and wraps back to its start.
module ddr3_ring_ptr #(
    parameter int ADDR_WIDTH = 28,
    parameter int ADDR_BEGIN = 0,
    parameter int ADDR_END   = 'h4000,
    parameter int STEP       = 'h400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam logic [ADDR_WIDTH-1:0] BEGIN_ADDR = ADDR_WIDTH'(ADDR_BEGIN);
    localparam logic [ADDR_WIDTH:0]   END_ADDR   = (ADDR_WIDTH+1)'(ADDR_END);

    // One extra bit so a window ending at the top of the address space still compares correctly.
    logic [ADDR_WIDTH:0] sum;
    assign sum = {1'b0, ptr} + (ADDR_WIDTH+1)'(STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= BEGIN_ADDR;
        end else if (clear) begin
            ptr <= BEGIN_ADDR;
        end else if (advance) begin
            ptr <= (sum == END_ADDR) ? BEGIN_ADDR : sum[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Grants the single MIG user port to the write or read burst engine, one burst
// at a time, treating a DDR address window as a ring buffer.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for MIG calibration
// ST_ARB     | pick next burst (round-robin on tie); apply pending flush
// ST_WR_REQ  | one-cycle write start issued
// ST_WR_WAIT | write engine busy, waiting for wr_burst_done
// ST_RD_REQ  | one-cycle read start issued
// ST_RD_WAIT | read engine busy, waiting for rd_burst_done
module ddr3_rw_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 28,
    parameter int FIFO_CNT_WIDTH = 10,
    parameter int RD_FIFO_DEPTH  = 512,
    parameter int BURST_LEN      = 64,
    parameter int ADDR_STEP      = 16,
    parameter int ADDR_BEGIN     = 0,
    parameter int ADDR_END       = 'h4000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_calib_complete,
    input  logic                      flush,
    input  logic [FIFO_CNT_WIDTH-1:0] wr_fifo_cnt,
    input  logic [FIFO_CNT_WIDTH-1:0] rd_fifo_cnt,
    output logic                      wr_burst_start,
    output logic [ADDR_WIDTH-1:0]     wr_burst_len,
    output logic [ADDR_WIDTH-1:0]     wr_burst_addr,
    input  logic                      wr_burst_done,
    output logic                      rd_burst_start,
    output logic [ADDR_WIDTH-1:0]     rd_burst_len,
    output logic [ADDR_WIDTH-1:0]     rd_burst_addr,
    input  logic                      rd_burst_done,
    output logic [ADDR_WIDTH-1:0]     ddr_fill,
    output logic                      arb_busy
);

    localparam int RING_BEATS = (ADDR_END - ADDR_BEGIN) / ADDR_STEP;
    localparam logic [ADDR_WIDTH-1:0] LEN      = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(RING_BEATS - BURST_LEN);

    arb_state_e state, state_nxt;
    grant_e     last_grant;
    logic       flush_pend;
    logic       ptr_clear;
    logic       wr_ok, rd_ok;
    logic       wr_adv, rd_adv;
    logic       in_burst;

    assign wr_burst_len = LEN;
    assign rd_burst_len = LEN;

    assign wr_ok = (32'(wr_fifo_cnt) >= 32'(BURST_LEN)) && (ddr_fill <= FILL_MAX);
    assign rd_ok = (32'(rd_fifo_cnt) + 32'(BURST_LEN) <= 32'(RD_FIFO_DEPTH)) && (ddr_fill >= LEN);

    // Done pulses only count in the matching wait state; anything else is spurious.
    assign wr_adv   = (state == ST_WR_WAIT) && wr_burst_done;
    assign rd_adv   = (state == ST_RD_WAIT) && rd_burst_done;
    assign in_burst = (state == ST_WR_REQ) || (state == ST_WR_WAIT) ||
                      (state == ST_RD_REQ) || (state == ST_RD_WAIT);

    always_comb begin
        state_nxt = state;
        ptr_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                ptr_clear = flush;
                if (init_calib_complete) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                ptr_clear = flush || flush_pend;
                if (!init_calib_complete) begin
                    state_nxt = ST_IDLE;
                end else if (ptr_clear) begin
                    state_nxt = ST_ARB;
                end else if (wr_ok && (!rd_ok || last_grant == GRANT_RD)) begin
                    state_nxt = ST_WR_REQ;
                end else if (rd_ok && (!wr_ok || last_grant == GRANT_WR)) begin
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_WR_REQ:  state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: if (wr_burst_done) state_nxt = ST_ARB;
            ST_RD_REQ:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (rd_burst_done) state_nxt = ST_ARB;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_grant     <= GRANT_RD;
            flush_pend     <= 1'b0;
            ddr_fill       <= '0;
            wr_burst_start <= 1'b0;
            rd_burst_start <= 1'b0;
            arb_busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            wr_burst_start <= (state_nxt == ST_WR_REQ);
            rd_burst_start <= (state_nxt == ST_RD_REQ);
            arb_busy       <= (state_nxt == ST_WR_REQ) || (state_nxt == ST_WR_WAIT) ||
                              (state_nxt == ST_RD_REQ) || (state_nxt == ST_RD_WAIT);

            if (state == ST_WR_REQ) last_grant <= GRANT_WR;
            else if (state == ST_RD_REQ) last_grant <= GRANT_RD;

            // A flush seen mid-burst is held until the next arbitration cycle.
            if (ptr_clear) flush_pend <= 1'b0;
            else if (flush && in_burst) flush_pend <= 1'b1;

            if (ptr_clear) ddr_fill <= '0;
            else if (wr_adv) ddr_fill <= ddr_fill + LEN;
            else if (rd_adv) ddr_fill <= ddr_fill - LEN;
        end
    end

    ddr3_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_BEGIN (ADDR_BEGIN),
        .ADDR_END   (ADDR_END),
        .STEP       (BURST_LEN * ADDR_STEP)
    ) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (wr_adv),
        .clear   (ptr_clear),
        .ptr     (wr_burst_addr)
    );

    ddr3_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_BEGIN (ADDR_BEGIN),
        .ADDR_END   (ADDR_END),
        .STEP       (BURST_LEN * ADDR_STEP)
    ) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (rd_adv),
        .clear   (ptr_clear),
        .ptr     (rd_burst_addr)
    );

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: directed phases push expected grants,
// a negedge monitor pops and checks each burst start.
module tb_ddr3_rw_arbiter;

    localparam int AW = 28;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_calib_complete = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] wr_fifo_cnt = '0;
    logic [CW-1:0] rd_fifo_cnt = '0;
    logic          wr_burst_start, rd_burst_start, arb_busy;
    logic          wr_burst_done = 1'b0;
    logic          rd_burst_done = 1'b0;
    logic [AW-1:0] wr_burst_len, wr_burst_addr, rd_burst_len, rd_burst_addr, ddr_fill;

    ddr3_rw_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .flush               (flush),
        .wr_fifo_cnt         (wr_fifo_cnt),
        .rd_fifo_cnt         (rd_fifo_cnt),
        .wr_burst_start      (wr_burst_start),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_done       (wr_burst_done),
        .rd_burst_start      (rd_burst_start),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_done       (rd_burst_done),
        .ddr_fill            (ddr_fill),
        .arb_busy            (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_wr;
        int addr;
        int fill;
        int gap;   // cycles from previous done to this start; 0 = not checked
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   nstarts = 0;
    int   last_done = 0;
    int   eng_cnt = 0;
    bit   eng_wr = 1'b0;
    bit   hold_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input bit w, input int addr, input int fill, input int gap);
        exp_t x;
        x.is_wr = w;
        x.addr  = addr;
        x.fill  = fill;
        x.gap   = gap;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (nstarts < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("start_count", nstarts, target);
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            quiet = arb_busy ? 0 : quiet + 1;
        end
        if (quiet < 6) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: arbiter still busy after %0d cycles", budget);
        end
    endtask

    // Burst engine model: done pulse three cycles after start, can be held off.
    initial begin
        forever begin
            @(negedge clk);
            wr_burst_done = 1'b0;
            rd_burst_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else if (eng_cnt > 0) begin
                if (!hold_done) eng_cnt--;
                if (eng_cnt == 0) begin
                    if (eng_wr) wr_burst_done = 1'b1;
                    else        rd_burst_done = 1'b1;
                    last_done = cyc;
                end
            end else if (wr_burst_start) begin
                eng_cnt = 3;
                eng_wr  = 1'b1;
            end else if (rd_burst_start) begin
                eng_cnt = 3;
                eng_wr  = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (wr_burst_start || rd_burst_start) begin
            nstarts++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_start: wr=%0d rd=%0d addr_w=0x%0h addr_r=0x%0h",
                         wr_burst_start, rd_burst_start, wr_burst_addr, rd_burst_addr);
            end else begin
                e = sb.pop_front();
                chk("start_channel_wr", wr_burst_start, e.is_wr);
                chk("start_channel_rd", rd_burst_start, !e.is_wr);
                chk("start_addr", e.is_wr ? wr_burst_addr : rd_burst_addr, e.addr);
                chk("start_len", e.is_wr ? wr_burst_len : rd_burst_len, 64);
                chk("start_fill", ddr_fill, e.fill);
                chk("start_busy", arb_busy, 1);
                if (e.gap != 0) chk("done_to_start_gap", cyc - last_done, e.gap);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk("rst_wr_start", wr_burst_start, 0);
        chk("rst_rd_start", rd_burst_start, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_fill", ddr_fill, 0);
        chk("rst_wr_addr", wr_burst_addr, 0);
        chk("rst_rd_addr", rd_burst_addr, 0);
        chk("rst_wr_len", wr_burst_len, 64);
        chk("rst_rd_len", rd_burst_len, 64);
        rst_n = 1'b1;

        // No grant before calibration
        wr_fifo_cnt = 64;
        step(20);
        chk("uncal_starts", nstarts, 0);

        // Write then read alternation at burst granularity
        push(1, 'h000, 0, 0);
        push(0, 'h000, 64, 2);
        push(1, 'h400, 0, 2);
        push(0, 'h400, 64, 2);
        init_calib_complete = 1'b1;
        wait_starts(4, 100);
        wr_fifo_cnt = 0;
        wait_idle(100);
        chk("a_fill", ddr_fill, 0);
        chk("a_wr_addr", wr_burst_addr, 'h800);
        chk("a_rd_addr", rd_burst_addr, 'h800);

        // Flush while arbitrating clears at once
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(1);
        chk("flush_arb_wr_addr", wr_burst_addr, 0);
        chk("flush_arb_rd_addr", rd_burst_addr, 0);
        chk("flush_arb_fill", ddr_fill, 0);

        // Fill the ring with 16 writes; read FIFO full blocks reads
        rd_fifo_cnt = 512;
        for (int k = 0; k < 16; k++) push(1, k * 'h400, k * 64, (k == 0) ? 0 : 2);
        wr_fifo_cnt = 512;
        wait_starts(20, 400);
        wait_idle(100);
        step(20);
        chk("full_fill", ddr_fill, 1024);
        chk("full_wr_addr_wrap", wr_burst_addr, 0);
        chk("full_blocked_starts", nstarts, 20);
        chk("full_busy", arb_busy, 0);

        // Read FIFO free space 52 < 64 blocks, 64 allows
        wr_fifo_cnt = 0;
        rd_fifo_cnt = 460;
        step(20);
        chk("rd_space_blocked", nstarts, 20);
        push(0, 'h000, 1024, 0);
        rd_fifo_cnt = 448;
        wait_starts(21, 50);
        rd_fifo_cnt = 512;
        wait_idle(100);
        chk("rd_fill", ddr_fill, 960);
        chk("rd_addr_adv", rd_burst_addr, 'h400);

        // Flush during a write burst is deferred to the next arbitration cycle
        hold_done = 1'b1;
        push(1, 'h000, 960, 0);
        wr_fifo_cnt = 64;
        wait_starts(22, 50);
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        chk("flush_wait_busy", arb_busy, 1);
        chk("flush_wait_fill", ddr_fill, 960);
        push(1, 'h000, 0, 3);
        hold_done = 1'b0;
        wait_starts(23, 50);
        wr_fifo_cnt = 0;
        chk("flush_rd_addr", rd_burst_addr, 0);
        wait_idle(100);
        chk("post_flush_fill", ddr_fill, 64);
        chk("post_flush_wr_addr", wr_burst_addr, 'h400);

        // Asynchronous reset in the middle of a read burst
        hold_done = 1'b1;
        push(0, 'h000, 64, 0);
        rd_fifo_cnt = 0;
        wait_starts(24, 50);
        rd_fifo_cnt = 512;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_start", wr_burst_start, 0);
        chk("arst_rd_start", rd_burst_start, 0);
        chk("arst_busy", arb_busy, 0);
        chk("arst_fill", ddr_fill, 0);
        chk("arst_wr_addr", wr_burst_addr, 0);
        chk("arst_rd_addr", rd_burst_addr, 0);
        hold_done = 1'b0;
        step(2);
        wr_fifo_cnt = 64;
        push(1, 'h000, 0, 0);
        rst_n = 1'b1;
        wait_starts(25, 50);
        wr_fifo_cnt = 0;
        wait_idle(100);
        chk("end_fill", ddr_fill, 64);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
